serial_adder: RTL

- Parametrised bit-serial adder/subtractor. Processes one bit per clock through a single full-adder cell, with a registered carry between bits.
- Adds add/subtract mode, signed-overflow detection and a start/busy/done handshake on top of the single-bit combinational full adder.
- Intended for area-constrained datapaths where WIDTH-cycle latency is acceptable. Sits between a register-file/operand source and a result consumer.

---
 rtl/serial_adder.sv | 64 ++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract through one full-adder cell, start/busy/done handshake
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] op_a, op_b;
  logic [CW-1:0] cnt;
  logic carry, s_bit, c_nx, last, accept;
  assign accept = start && state != RUN;
  assign last = cnt == CW'(WIDTH - 1);
  assign s_bit = op_a[0] ^ op_b[0] ^ carry;
  assign c_nx = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = RUN;
    else if (state == RUN) state_nx = last ? DONE : RUN;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // op_a doubles as the result shift register: sum bits enter at the MSB as operand bits leave at the LSB
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_a <= a;
      op_b <= sub ? ~b : b;
      carry <= sub;
      cnt <= '0;
    end else if (state == RUN) begin
      op_a <= {s_bit, op_a[WIDTH-1:1]};
      op_b <= {1'b0, op_b[WIDTH-1:1]};
      carry <= c_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        sum <= {s_bit, op_a[WIDTH-1:1]};
        cout <= c_nx;
        overflow <= carry ^ c_nx;
      end
    end
endmodule
